// File: rtl/prf_ckpt_pkg.sv
// Shared types and default sizing for the register file / rename map
// and the branch checkpoint FIFO.
package prf_ckpt_pkg;

    localparam int PIPE_WIDTH   = 2;
    localparam int COMMIT_WIDTH = 2;
    localparam int ARCH_REGS    = 32;
    localparam int DATA_BITS    = 32;
    localparam int TAG_WIDTH    = 6;
    localparam int NUM_CKPT     = 4;

    localparam int AREG_W = $clog2(ARCH_REGS);

    typedef logic [$clog2(NUM_CKPT)-1:0] ckpt_id_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [TAG_WIDTH-1:0] tag;
        logic                 is_renamed;
    } source_t;

    typedef struct packed {
        logic                 we;
        logic [AREG_W-1:0]    addr;
        logic [TAG_WIDTH-1:0] tag;
    } prf_rat_write_port_t;

    typedef struct packed {
        logic                 we;
        logic [AREG_W-1:0]    addr;
        logic [TAG_WIDTH-1:0] tag;
        logic [DATA_BITS-1:0] data;
    } prf_commit_write_port_t;

endpackage

// File: rtl/prf_ckpt_fifo_ctrl.sv
// Head/tail/count bookkeeping for the in-order checkpoint FIFO, including
// truncation of the youngest entries on a mispredict restore.
module prf_ckpt_fifo_ctrl #(
    parameter int NUM_CKPT = prf_ckpt_pkg::NUM_CKPT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        alloc,
    input  logic                        rel,
    input  logic                        restore,
    input  logic [$clog2(NUM_CKPT)-1:0] restore_id,
    output logic                        ready,
    output logic [$clog2(NUM_CKPT)-1:0] tail_id
);

    localparam int IW = $clog2(NUM_CKPT);

    logic [IW-1:0] head_q;
    logic [IW-1:0] tail_q;
    logic [IW:0]   count_q;
    logic [IW-1:0] head_rel;

    assign ready    = count_q < (IW+1)'(NUM_CKPT);
    assign tail_id  = tail_q;
    assign head_rel = rel ? head_q + IW'(1) : head_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (restore) begin
            // Release is applied first; the restored id and everything younger is freed.
            head_q  <= head_rel;
            tail_q  <= restore_id;
            count_q <= {1'b0, restore_id - head_rel};
        end else begin
            head_q  <= head_rel;
            if (alloc) tail_q <= tail_q + IW'(1);
            count_q <= count_q + (IW+1)'(alloc) - (IW+1)'(rel);
        end
    end

endmodule

// File: rtl/prf_ckpt.sv
// Physical register file with speculative rename map, same-group rename
// bypass to younger readers, and snapshot/restore of the map on branches.
module prf_ckpt #(
    parameter int PIPE_WIDTH   = prf_ckpt_pkg::PIPE_WIDTH,
    parameter int COMMIT_WIDTH = prf_ckpt_pkg::COMMIT_WIDTH,
    parameter int ARCH_REGS    = prf_ckpt_pkg::ARCH_REGS,
    parameter int DATA_BITS    = prf_ckpt_pkg::DATA_BITS,
    parameter int TAG_WIDTH    = prf_ckpt_pkg::TAG_WIDTH,
    parameter int NUM_CKPT     = prf_ckpt_pkg::NUM_CKPT
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               flush,
    input  logic [PIPE_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]       rs1_addr,
    input  logic [PIPE_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]       rs2_addr,
    output prf_ckpt_pkg::source_t [PIPE_WIDTH-1:0]             rs1_out,
    output prf_ckpt_pkg::source_t [PIPE_WIDTH-1:0]             rs2_out,
    input  logic [PIPE_WIDTH-1:0]                              rat_we,
    input  logic [PIPE_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]       rat_addr,
    input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]               rat_tag,
    input  logic                                               ckpt_req,
    input  logic [$clog2(PIPE_WIDTH)-1:0]                      ckpt_slot,
    output logic                                               ckpt_ready,
    output prf_ckpt_pkg::ckpt_id_t                             ckpt_id,
    input  logic                                               release_valid,
    input  logic                                               restore_valid,
    input  prf_ckpt_pkg::ckpt_id_t                             restore_id,
    input  logic [COMMIT_WIDTH-1:0]                            commit_we,
    input  logic [COMMIT_WIDTH-1:0][$clog2(ARCH_REGS)-1:0]     commit_addr,
    input  logic [COMMIT_WIDTH-1:0][TAG_WIDTH-1:0]             commit_tag,
    input  logic [COMMIT_WIDTH-1:0][DATA_BITS-1:0]             commit_data
);

    import prf_ckpt_pkg::*;

    localparam int AW = $clog2(ARCH_REGS);
    localparam int SW = $clog2(PIPE_WIDTH);

    logic [DATA_BITS-1:0] data_q [ARCH_REGS];
    logic [TAG_WIDTH-1:0] tag_q  [ARCH_REGS];
    logic [ARCH_REGS-1:0] ren_q;
    logic [TAG_WIDTH-1:0] snap_tag_q [NUM_CKPT][ARCH_REGS];
    logic [ARCH_REGS-1:0] snap_ren_q [NUM_CKPT];

    logic [DATA_BITS-1:0] data_d [ARCH_REGS];
    logic [TAG_WIDTH-1:0] tag_d  [ARCH_REGS];
    logic [ARCH_REGS-1:0] ren_d;
    logic [TAG_WIDTH-1:0] cap_tag [ARCH_REGS];
    logic [ARCH_REGS-1:0] cap_ren;
    logic [TAG_WIDTH-1:0] snap_tag_cl [NUM_CKPT][ARCH_REGS];
    logic [ARCH_REGS-1:0] snap_ren_cl [NUM_CKPT];
    logic                 alloc;

    function automatic logic commit_hits(
        input logic [AW-1:0]                          r,
        input logic [TAG_WIDTH-1:0]                   t,
        input logic [COMMIT_WIDTH-1:0]                we,
        input logic [COMMIT_WIDTH-1:0][AW-1:0]        addr,
        input logic [COMMIT_WIDTH-1:0][TAG_WIDTH-1:0] ctag
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < COMMIT_WIDTH; p++) begin
            if (we[p] && addr[p] == r && ctag[p] == t) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic source_t lookup(
        input logic [AW-1:0]                        r,
        input int                                   slot,
        input logic [DATA_BITS-1:0]                 d,
        input logic [TAG_WIDTH-1:0]                 t,
        input logic                                 rn,
        input logic [PIPE_WIDTH-1:0]                we,
        input logic [PIPE_WIDTH-1:0][AW-1:0]        wa,
        input logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] wt
    );
        source_t s;
        s.data       = d;
        s.tag        = t;
        s.is_renamed = rn;
        // Older slots in the same rename group override the stored mapping.
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            if (i < slot && we[i] && wa[i] == r) begin
                s.tag        = wt[i];
                s.is_renamed = 1'b1;
            end
        end
        if (r == '0) s = '0;
        return s;
    endfunction

    always_comb begin
        for (int j = 0; j < PIPE_WIDTH; j++) begin
            rs1_out[j] = lookup(rs1_addr[j], j, data_q[rs1_addr[j]], tag_q[rs1_addr[j]],
                                ren_q[rs1_addr[j]], rat_we, rat_addr, rat_tag);
            rs2_out[j] = lookup(rs2_addr[j], j, data_q[rs2_addr[j]], tag_q[rs2_addr[j]],
                                ren_q[rs2_addr[j]], rat_we, rat_addr, rat_tag);
        end
    end

    assign alloc = ckpt_req && ckpt_ready && !restore_valid && !flush;

    always_comb begin
        for (int r = 0; r < ARCH_REGS; r++) begin
            data_d[r] = data_q[r];
            tag_d[r]  = tag_q[r];
        end
        ren_d = ren_q;

        for (int p = 0; p < COMMIT_WIDTH; p++) begin
            if (commit_we[p] && commit_addr[p] != '0) data_d[commit_addr[p]] = commit_data[p];
        end

        for (int s = 0; s < NUM_CKPT; s++) begin
            snap_ren_cl[s] = snap_ren_q[s];
            for (int r = 0; r < ARCH_REGS; r++) begin
                snap_tag_cl[s][r] = snap_tag_q[s][r];
                if (snap_ren_q[s][r] &&
                    commit_hits(AW'(r), snap_tag_q[s][r], commit_we, commit_addr, commit_tag)) begin
                    snap_tag_cl[s][r] = '0;
                    snap_ren_cl[s][r] = 1'b0;
                end
            end
        end

        for (int r = 0; r < ARCH_REGS; r++) begin
            if (ren_q[r] && commit_hits(AW'(r), tag_q[r], commit_we, commit_addr, commit_tag)) begin
                tag_d[r] = '0;
                ren_d[r] = 1'b0;
            end
        end

        for (int r = 0; r < ARCH_REGS; r++) cap_tag[r] = tag_d[r];
        cap_ren = ren_d;

        if (restore_valid) begin
            for (int r = 0; r < ARCH_REGS; r++) tag_d[r] = snap_tag_cl[restore_id][r];
            ren_d = snap_ren_cl[restore_id];
        end else begin
            // Renames applied in slot order so the highest slot wins; the snapshot
            // is taken right after the branch's own slot.
            for (int i = 0; i < PIPE_WIDTH; i++) begin
                if (rat_we[i] && rat_addr[i] != '0) begin
                    tag_d[rat_addr[i]] = rat_tag[i];
                    ren_d[rat_addr[i]] = 1'b1;
                end
                if (SW'(i) == ckpt_slot) begin
                    for (int r = 0; r < ARCH_REGS; r++) cap_tag[r] = tag_d[r];
                    cap_ren = ren_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            ren_q <= '0;
            for (int s = 0; s < NUM_CKPT; s++) begin
                snap_ren_q[s] <= '0;
                for (int r = 0; r < ARCH_REGS; r++) snap_tag_q[s][r] <= '0;
            end
        end else if (flush) begin
            ren_q <= '0;
            for (int s = 0; s < NUM_CKPT; s++) snap_ren_q[s] <= '0;
        end else begin
            for (int r = 0; r < ARCH_REGS; r++) begin
                data_q[r] <= data_d[r];
                tag_q[r]  <= tag_d[r];
            end
            ren_q <= ren_d;
            for (int s = 0; s < NUM_CKPT; s++) begin
                snap_ren_q[s] <= snap_ren_cl[s];
                for (int r = 0; r < ARCH_REGS; r++) snap_tag_q[s][r] <= snap_tag_cl[s][r];
            end
            if (alloc) begin
                snap_ren_q[ckpt_id] <= cap_ren;
                for (int r = 0; r < ARCH_REGS; r++) snap_tag_q[ckpt_id][r] <= cap_tag[r];
            end
        end
    end

    prf_ckpt_fifo_ctrl #(
        .NUM_CKPT (NUM_CKPT)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alloc      (alloc),
        .rel        (release_valid),
        .restore    (restore_valid),
        .restore_id (restore_id),
        .ready      (ckpt_ready),
        .tail_id    (ckpt_id)
    );

endmodule
